hack_screen_reader: RTL

- Scanout engine for the Hack screen map: reads the 8K-word, 512x256 monochrome framebuffer (CPU address 0x4000-0x5FFF) through a dedicated read port and serialises it into a pixel stream with sync/blank timing for the MiSTer video path.
- Read-side counterpart of the CPU's memory-mapped screen writes.
- Owns the raster counters, word prefetch and the pixel shift register.

---
 rtl/hack_screen_reader.sv | 108 ++++++++++
 1 files changed

// File: rtl/hack_screen_reader.sv
// hack_screen_reader: scans the Hack 512x256 framebuffer out as a 1-bpp pixel stream with sync/blank timing.
// Define HACK_SCREEN_LINEDBL_EN for 512-line output (each Hack row fetched and shown twice).
module hack_screen_reader #(
  parameter int H_ACTIVE = 512,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 80,
`ifdef HACK_SCREEN_LINEDBL_EN
  parameter int V_ACTIVE = 512,
`else
  parameter int V_ACTIVE = 256,
`endif
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  output logic [12:0] ram_addr,
  input  logic [15:0] ram_rdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d, nv;
  logic [12:0] addr_q, addr_d;
  logic [15:0] shift_q, shift_d, word_q;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic        pixel_q, pixel_d, fs_q, fs_d;
  logic        h_last, v_last, h_act, v_act, nv_act, load;
  logic [7:0]  row, nrow;
  always_comb begin
    h_last   = hcount_q == 10'(H_TOTAL - 1);
    v_last   = vcount_q == 10'(V_TOTAL - 1);
    h_act    = hcount_q < 10'(H_ACTIVE);
    v_act    = vcount_q < 10'(V_ACTIVE);
    nv       = v_last ? '0 : vcount_q + 10'd1;
    nv_act   = nv < 10'(V_ACTIVE);
`ifdef HACK_SCREEN_LINEDBL_EN
    row      = vcount_q[8:1];
    nrow     = nv[8:1];
`else
    row      = vcount_q[7:0];
    nrow     = nv[7:0];
`endif
    load     = h_last || (h_act && hcount_q[3:0] == 4'hf && hcount_q != 10'(H_ACTIVE - 1));
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    pixel_d  = pixel_q;
    fs_d     = ce_pix && hcount_q == '0 && vcount_q == '0;
    if (ce_pix) begin
      hcount_d = h_last ? '0 : hcount_q + 10'd1;
      vcount_d = h_last ? nv : vcount_q;
      de_d     = h_act && v_act;
      pixel_d  = h_act && v_act && shift_q[0];
      hsync_d  = hcount_q >= 10'(H_ACTIVE + H_FP) && hcount_q < 10'(H_ACTIVE + H_FP + H_SYNC);
      vsync_d  = vcount_q >= 10'(V_ACTIVE + V_FP) && vcount_q < 10'(V_ACTIVE + V_FP + V_SYNC);
      shift_d  = load ? word_q : h_act ? {1'b0, shift_q[15:1]} : shift_q;
      // next row's word 0 is requested late in the line so it is ready for the load at H_TOTAL-1
      if (hcount_q == 10'(H_TOTAL - 8) && nv_act)
        addr_d = {nrow, 5'd0};
      else if (v_act && hcount_q[3:0] == 4'd8 && hcount_q < 10'(H_ACTIVE - 16))
        addr_d = {row, hcount_q[8:4] + 5'd1};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      pixel_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      // word_buf follows the read port every clk, so it settles well before the next shifter load
      word_q   <= ram_rdata;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      pixel_q  <= pixel_d;
      fs_q     <= fs_d;
    end
  end
  assign ram_addr    = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;
endmodule
